sat_sample_collector: RTL

//  Downstream stage of the mirror-formula evaluator. Consumes one
//  (input-vector, formula-verdict) pair per handshake.

---
 rtl/sat_collect_pkg.sv | 16 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/sat_sample_collector.sv | 109 ++++++++++
 3 files changed

// File: rtl/sat_collect_pkg.sv
// Shared types and helpers for the satisfying-sample collector.
package sat_collect_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Width needed to hold an occupancy count from 0 up to depth inclusive.
    function automatic int clog2p1(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage. The head entry becomes visible
// the cycle after it is written. The output is forced to zero when empty so
// that nothing stale or undefined leaks out.
module sync_fifo
    import sat_collect_pkg::*;
#(
    parameter  int W     = 40,
    parameter  int DEPTH = 16,
    localparam int LW    = clog2p1(DEPTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A flush overrides any push or pop in the same cycle.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

    // Storage write; no reset needed because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sat_sample_collector.sv
// Collects satisfying input vectors from the formula evaluator into a FIFO,
// counts total and satisfying samples, and stops after MAX_SAT hits.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | after reset; nothing accepted, waiting for start
//   S_RUN   | accepting samples while the FIFO has room
//   S_DRAIN | MAX_SAT reached; input closed, FIFO being emptied
//   S_DONE  | FIFO empty after a completed run; counters held until start
module sat_sample_collector
    import sat_collect_pkg::*;
#(
    parameter  int NUM_IN  = 40,
    parameter  int DEPTH   = 16,
    parameter  int CNT_W   = 32,
    parameter  int MAX_SAT = 1000,
    localparam int LW      = clog2p1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] in_vec,
    input  logic              in_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_IN-1:0] out_vec,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [CNT_W-1:0]  sat_cnt,
    output logic [LW-1:0]     fifo_level,
    output logic              busy,
    output logic              done
);

    // sat_cnt value just before the final satisfying sample is accepted.
    localparam logic [CNT_W-1:0] SAT_LAST = (MAX_SAT == 0) ? '0 : CNT_W'(MAX_SAT - 1);

    state_t state;
    state_t state_nxt;
    logic   full;
    logic   empty;
    logic   accept;
    logic   push;
    logic   pop;
    logic   flush;
    logic   sat_last;
    logic   drain_empty;

    // start only means something from IDLE or DONE, and then it beats any pop.
    assign flush       = start & ((state == S_IDLE) | (state == S_DONE));
    assign in_ready    = (state == S_RUN) & ~full;
    assign accept      = in_valid & in_ready;
    assign push        = accept & in_sat;
    assign pop         = out_ready & ~empty & ~flush;
    assign out_valid   = ~empty;
    assign busy        = (state == S_RUN) | (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign sat_last    = (MAX_SAT != 0) && push && (sat_cnt == SAT_LAST);
    // Leave DRAIN on the same edge that removes the last entry, so done and an
    // empty FIFO show up together.
    assign drain_empty = empty | ((fifo_level == LW'(1)) & pop);

    sync_fifo #(
        .W     (NUM_IN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_vec),
        .dout  (out_vec),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)       state_nxt = S_RUN;
            S_RUN:   if (sat_last)    state_nxt = S_DRAIN;
            S_DRAIN: if (drain_empty) state_nxt = S_DONE;
            S_DONE:  if (start)       state_nxt = S_RUN;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // Sample counters; cleared by a honoured start, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            total_cnt <= '0;
            sat_cnt   <= '0;
        end else if (accept) begin
            if (total_cnt != '1)          total_cnt <= total_cnt + 1'b1;
            if (in_sat && sat_cnt != '1)  sat_cnt   <= sat_cnt + 1'b1;
        end
    end

endmodule
